// File: rtl/tx_block_serializer.sv
// -----------------------------------------------------------------------------
// tx_block_serializer
//
// Reader end of the transmit FIFO. Pops one BLOCK_BITS word at a time and
// streams it out MSB-first as BEATS beats of OUT_BITS over a valid/ready
// handshake. The FIFO pops on a rising edge of its read enable, so exactly one
// single-cycle registered pulse is issued per block consumed.
//
// Optional feature (compile-time macro TX_BLOCK_CNT_EN):
//   adds a 16-bit wrapping counter of completed blocks on port blocks_sent.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   fifo_empty        FIFO has no valid head word
//   fifo_read_data    FIFO head word (valid when fifo_empty = 0)
//   fifo_read_enable  registered pop pulse, one cycle per block
//   tx_data           current output beat
//   tx_valid          tx_data holds a valid beat
//   tx_ready          downstream accepts beat when tx_valid & tx_ready
//   tx_last           current beat is the final beat of its block
//   busy              high while sending a block
//   blocks_sent       (TX_BLOCK_CNT_EN only) completed-block count, wraps
// -----------------------------------------------------------------------------
module tx_block_serializer #(
    parameter int BLOCK_BITS = 128,
    parameter int OUT_BITS   = 8,
    localparam int BEATS     = BLOCK_BITS / OUT_BITS,
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [BLOCK_BITS-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    output logic [OUT_BITS-1:0]   tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy
`ifdef TX_BLOCK_CNT_EN
    ,
    output logic [15:0]           blocks_sent
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [BLOCK_BITS-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]        beat_cnt_reg, beat_cnt_next;
    logic                    rd_en_reg, rd_en_next;

    logic                    last_beat;
    logic                    beat_xfer;
    logic                    last_xfer;
    logic [BLOCK_BITS-1:0]   shifted;

    assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));
    assign beat_xfer = (state_reg == SEND) && tx_ready;
    assign last_xfer = beat_xfer && last_beat;

    // Shifting zeros in means the register is all-zero once a block drains,
    // so tx_data naturally reads 0 while idle.
    assign shifted = {shift_reg[BLOCK_BITS-OUT_BITS-1:0], {OUT_BITS{1'b0}}};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            beat_cnt_reg <= '0;
            rd_en_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            beat_cnt_reg <= beat_cnt_next;
            rd_en_reg    <= rd_en_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        beat_cnt_next = beat_cnt_reg;
        rd_en_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_next    = fifo_read_data;
                    beat_cnt_next = '0;
                    rd_en_next    = 1'b1;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (beat_xfer) begin
                    if (last_beat) begin
                        beat_cnt_next = '0;
                        if (!fifo_empty) begin
                            // Back-to-back: the previous pop happened BEATS-1
                            // edges ago, so fifo_empty already reflects it.
                            shift_next = fifo_read_data;
                            rd_en_next = 1'b1;
                        end else begin
                            shift_next = shifted;
                            state_next = IDLE;
                        end
                    end else begin
                        shift_next    = shifted;
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fifo_read_enable = rd_en_reg;
    assign tx_valid         = (state_reg == SEND);
    assign busy             = (state_reg == SEND);
    assign tx_last          = (state_reg == SEND) && last_beat;
    assign tx_data          = shift_reg[BLOCK_BITS-1 -: OUT_BITS];

`ifdef TX_BLOCK_CNT_EN
    logic [15:0] blocks_sent_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_sent_reg <= '0;
        end else if (last_xfer) begin
            blocks_sent_reg <= blocks_sent_reg + 16'd1;
        end
    end

    assign blocks_sent = blocks_sent_reg;
`else
    logic unused_last_xfer;
    assign unused_last_xfer = last_xfer;
`endif

endmodule

// File: tb/tb_tx_block_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_block_serializer
//
// Bench for tx_block_serializer. A small array-based FIFO model pops on a
// rising edge of fifo_read_enable. Every pushed block is expanded into its
// expected byte sequence (MSB byte first) in a scoreboard queue; each cycle the
// beat on the bus is compared with the queue head and retired on handshake.
// -----------------------------------------------------------------------------
module tb_tx_block_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [127:0] fifo_read_data;
    logic         fifo_read_enable;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_last;
    logic         busy;
`ifdef TX_BLOCK_CNT_EN
    logic [15:0]  blocks_sent;
    int           exp_cnt = 0;
`endif

    always #5 clk = ~clk;

    tx_block_serializer dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (fifo_read_enable),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_last          (tx_last),
        .busy             (busy)
`ifdef TX_BLOCK_CNT_EN
        ,
        .blocks_sent      (blocks_sent)
`endif
    );

    // FIFO model: head shown combinationally, pop on rising read enable.
    logic [127:0] mem [0:63];
    int           rd_ptr  = 0;
    int           wr_ptr  = 0;
    logic         re_prev = 1'b0;

    assign fifo_empty     = (rd_ptr == wr_ptr);
    assign fifo_read_data = mem[rd_ptr % 64];

    always @(posedge clk) begin
        re_prev <= fifo_read_enable;
        if (fifo_read_enable && !re_prev) rd_ptr <= rd_ptr + 1;
    end

    // Scoreboard and bookkeeping
    logic [7:0] exp_q[$];
    int checks       = 0;
    int errors       = 0;
    int beat_in_blk  = 0;
    int blocks_done  = 0;
    int pulses       = 0;
    int valid_cycles = 0;
    int cur_run      = 0;
    int max_run      = 0;
    int cyc          = 0;
    int last_pulse   = -1;
    int pulse_gap    = 0;
    logic last_re    = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input logic [127:0] blk);
        mem[wr_ptr % 64] = blk;
        wr_ptr++;
        for (int i = 0; i < 16; i++) exp_q.push_back(blk[127-8*i -: 8]);
    endtask

    // One clock cycle: check the outputs visible now, retire a beat if it
    // transfers at the coming edge, then advance to just after that edge.
    task automatic cycle();
        check("busy_eq_valid", busy, tx_valid);
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", tx_valid, 1'b0);
            end else begin
                check("tx_data", tx_data, exp_q[0]);
                check("tx_last", tx_last, (beat_in_blk == 15));
            end
        end else begin
            check("idle_data", tx_data, 8'h00);
            check("idle_last", tx_last, 1'b0);
        end
        if (beat_in_blk != 0) check("valid_mid_block", tx_valid, 1'b1);
        if (fifo_read_enable) begin
            check("rd_en_context", {tx_valid, (beat_in_blk == 0), last_re}, 3'b110);
            pulses++;
            if (last_pulse >= 0) pulse_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
`ifdef TX_BLOCK_CNT_EN
        check("blocks_sent", blocks_sent, exp_cnt[15:0]);
`endif
        if (tx_valid) begin
            valid_cycles++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (tx_valid && tx_ready && !rst && exp_q.size() != 0) begin
            exp_q.delete(0);
            beat_in_blk = (beat_in_blk + 1) % 16;
            if (beat_in_blk == 0) begin
                blocks_done++;
`ifdef TX_BLOCK_CNT_EN
                exp_cnt = (exp_cnt + 1) % 65536;
`endif
            end
        end
        last_re = fifo_read_enable;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic window_start();
        valid_cycles = 0;
        cur_run      = 0;
        max_run      = 0;
        last_pulse   = -1;
        pulse_gap    = 0;
    endtask

    initial begin
        int p0, b0, budget;
        logic [127:0] blk;

        rst      = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_valid", tx_valid, 1'b0);
        check("rst_last", tx_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_rd_en", fifo_read_enable, 1'b0);
`ifdef TX_BLOCK_CNT_EN
        check("rst_blocks_sent", blocks_sent, 16'h0000);
`endif
        rst = 1'b0;
        cycle();

        // Single block, ready held high
        window_start();
        p0 = pulses; b0 = blocks_done;
        tx_ready = 1'b1;
        push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        cycle();
        check("latency_valid", tx_valid, 1'b1);
        repeat (20) cycle();
        check("single_pulses", pulses - p0, 1);
        check("single_blocks", blocks_done - b0, 1);
        check("single_valid_cycles", valid_cycles, 16);
        check("single_end_idle", tx_valid, 1'b0);

        // Backpressure at beat 3 for 5 cycles
        window_start();
        p0 = pulses;
        blk = {$urandom, $urandom, $urandom, $urandom};
        push_block(blk);
        budget = 0;
        while (!(tx_valid && beat_in_blk == 3) && budget < 50) begin
            cycle();
            budget++;
        end
        check("bp_reach_beat3", budget < 50, 1'b1);
        tx_ready = 1'b0;
        repeat (5) cycle();
        tx_ready = 1'b1;
        repeat (20) cycle();
        check("bp_valid_cycles", valid_cycles, 21);
        check("bp_pulses", pulses - p0, 1);
        check("bp_drained", exp_q.size(), 0);

        // Back-to-back blocks
        window_start();
        p0 = pulses; b0 = blocks_done;
        push_block({$urandom, $urandom, $urandom, $urandom});
        push_block({$urandom, $urandom, $urandom, $urandom});
        repeat (40) cycle();
        check("b2b_valid_cycles", valid_cycles, 32);
        check("b2b_contiguous", max_run, 32);
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_pulse_gap", pulse_gap, 16);
        check("b2b_blocks", blocks_done - b0, 2);

        // Empty FIFO with ready toggling
        window_start();
        p0 = pulses;
        for (int i = 0; i < 50; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check("empty_valid_cycles", valid_cycles, 0);
        check("empty_pulses", pulses - p0, 0);

        // Reset at beat 7 with a second block queued
        tx_ready = 1'b1;
        push_block({$urandom, $urandom, $urandom, $urandom});
        push_block({$urandom, $urandom, $urandom, $urandom});
        budget = 0;
        while (!(tx_valid && beat_in_blk == 7) && budget < 50) begin
            cycle();
            budget++;
        end
        check("rst_mid_reach_beat7", budget < 50, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        while (beat_in_blk != 0) begin
            exp_q.delete(0);
            beat_in_blk = (beat_in_blk + 1) % 16;
        end
`ifdef TX_BLOCK_CNT_EN
        exp_cnt = 0;
`endif
        check("rst_mid_valid", tx_valid, 1'b0);
        check("rst_mid_rd_en", fifo_read_enable, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        b0 = blocks_done;
        repeat (20) cycle();
        check("rst_mid_restart_blocks", blocks_done - b0, 1);
        check("rst_mid_drained", exp_q.size(), 0);

        // Random traffic with random backpressure
        p0 = pulses; b0 = blocks_done;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0 && (wr_ptr - rd_ptr) < 50)
                push_block({$urandom, $urandom, $urandom, $urandom});
            tx_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        tx_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || tx_valid) && budget < 3000) begin
            cycle();
            budget++;
        end
        check("rand_drain_in_time", budget < 3000, 1'b1);
        check("rand_scoreboard_empty", exp_q.size(), 0);
        check("rand_pulses_eq_blocks", pulses - p0, blocks_done - b0);
        check("rand_fifo_empty", fifo_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_block_serializer.md
Name: tx_block_serializer

Overview:
Drains 128-bit blocks from the transmit FIFO and emits them as a byte stream over a valid/ready handshake toward the link/PHY side. It is the reader end of the transmit FIFO. The FIFO presents its head word combinationally and pops on a rising edge of its read enable. This block therefore issues exactly one single-cycle read-enable pulse per block consumed.

Parameters:
BLOCK_BITS, 128, width of a FIFO word; must be a multiple of OUT_BITS
OUT_BITS, 8, width of one output beat
BEATS, BLOCK_BITS/OUT_BITS (16), beats per block; derived, not overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO has no valid head word
fifo_read_data  input  BLOCK_BITS  FIFO head word, valid whenever fifo_empty=0
fifo_read_enable  output  1  registered pop pulse to FIFO, high exactly one cycle per block
tx_data  output  OUT_BITS  current output beat
tx_valid  output  1  tx_data holds a valid beat
tx_ready  input  1  downstream accepts the beat when tx_valid & tx_ready
tx_last  output  1  current beat is the final beat (index BEATS-1) of its block
busy  output  1  high in SEND state

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, shift register=0, beat_cnt=0.
- Reset outputs: fifo_read_enable=0, tx_valid=0, tx_last=0, busy=0, tx_data=0.
- Reset mid-block discards the remaining beats. That block has already been popped and is lost.
- States: IDLE, SEND.
- IDLE with fifo_empty=0: at the next edge
  - capture fifo_read_data into the shift register
  - beat_cnt<=0, fifo_read_enable<=1, state<=SEND
- IDLE with fifo_empty=1: remain in IDLE, all outputs 0.
- SEND:
  - tx_valid=1; tx_data = shift register bits [BLOCK_BITS-1 -: OUT_BITS]. MSB byte is sent first, so block bits 127:120 are beat 0.
  - tx_last = (beat_cnt==BEATS-1).
  - fifo_read_enable is high only in the first SEND cycle, then returns to 0.
- Handshake: a beat transfers on a clk edge with tx_valid & tx_ready.
  - Transfer: shift register shifts left by OUT_BITS; beat_cnt increments (4-bit, BEATS-1 -> 0).
  - While tx_valid=1 and tx_ready=0: tx_data, tx_last and beat_cnt hold stable. tx_valid never drops mid-block.
- Last-beat transfer (beat_cnt==BEATS-1 with handshake):
  - If fifo_empty=0: load the next block in the same edge, pulse fifo_read_enable again, stay in SEND (back-to-back).
  - Otherwise: go to IDLE.
- Pop timing:
  - The FIFO pops at the edge after the read-enable pulse; fifo_empty is re-evaluated by the next load.
  - Minimum spacing between pulses is BEATS cycles, so read enable is always low for at least one cycle between pops. This is required for edge detection.
- Latency: fifo_empty falling while in IDLE -> tx_valid=1 with beat 0 on the next cycle.
- Throughput: one block per BEATS cycles with tx_ready held high.
- tx_ready is ignored in IDLE. fifo_read_data is sampled only at load edges.

Optional Feature:
Macro TX_BLOCK_CNT_EN.
- Defined: adds output port blocks_sent (16 bits).
  - Resets to 0.
  - Increments by 1 on each last-beat transfer; wraps 0xFFFF -> 0.
  - Unaffected by stall cycles.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single block, data 0x00112233_44556677_8899AABB_CCDDEEFF, tx_ready=1 → fifo_read_enable pulses once; tx_data = 0x00,0x11,...,0xFF on 16 consecutive cycles; tx_last only with 0xFF; then IDLE with tx_valid=0.
- Backpressure: tx_ready=0 for 5 cycles at beat 3 → tx_data holds 0x33 and tx_valid=1 for all 5 cycles; stream resumes with 0x44; total 21 cycles; still exactly one read pulse.
- Back-to-back: FIFO holds blocks A and B, tx_ready=1 → 32 contiguous valid beats; read pulses at cycles 1 and 17; tx_last at beats 15 and 31; no idle gap.
- Empty FIFO: fifo_empty=1 for 50 cycles → tx_valid=0 and fifo_read_enable=0 throughout; tx_ready toggling has no effect.
- Reset mid-block: rst=1 for one cycle at beat 7 → next cycle tx_valid=0, fifo_read_enable=0, busy=0; with a queued block, restart from that block's beat 0.
- TX_BLOCK_CNT_EN defined: send 3 blocks → blocks_sent steps 0→1→2→3, each step at a last-beat edge; preload to 0xFFFF, one block → wraps to 0.
